// File: rtl/buffer_pkg.sv
// Shared constants and helpers for the parametrised addressed buffer.
package buffer_pkg;

  localparam int BUF_DATA_W = 64;
  localparam int BUF_DEPTH  = 8;

  // Ceiling log2, usable in parameter defaults.
  function automatic int buf_addr_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/buffer_valid_tracker.sv
// Per-entry valid bits plus incrementally maintained occupancy, full and empty.
module buffer_valid_tracker
  import buffer_pkg::*;
#(
  parameter int DEPTH  = BUF_DEPTH,
  parameter int ADDR_W = buf_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  valid,
  output logic [ADDR_W:0]   occupancy,
  output logic              full,
  output logic              empty
);

  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             full_q, empty_q;
  logic             clr_eff, inc;

  // Next valid vector and occupancy; a write to the cleared address wins.
  always_comb begin
    clr_eff = clr_en & valid_q[clr_addr] & ~(wr_en & (wr_addr == clr_addr));
    inc     = wr_en & ~valid_q[wr_addr];
    valid_d = valid_q;
    if (clr_eff) valid_d[clr_addr] = 1'b0;
    if (wr_en)   valid_d[wr_addr]  = 1'b1;
    occ_d   = occ_q + CNT_W'(inc) - CNT_W'(clr_eff);
  end

  // State registers; flags are derived from next occupancy so they agree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      full_q  <= (occ_d == FULL_CNT);
      empty_q <= (occ_d == '0);
    end
  end

  assign valid     = valid_q;
  assign occupancy = occ_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: rtl/buffer_top_param.sv
// Parametrised dual-port addressed buffer: byte-enabled writes, registered
// reads with hit flag, clear-on-read, occupancy and a sticky invalid-read error.
// Build option: BUF_WR_BYPASS_EN forwards same-cycle write data to a read of
// the same address (merged bytes, hit forced to 1).
module buffer_top_param
  import buffer_pkg::*;
#(
  parameter int DATA_W = BUF_DATA_W,
  parameter int DEPTH  = BUF_DEPTH,
  parameter int ADDR_W = buf_addr_w(DEPTH),
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in_wr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [BE_W-1:0]   in_be,
  input  logic              wr_en_0,
  input  logic [ADDR_W-1:0] addr_in_rd,
  input  logic              op_en_1,
  input  logic              clr_on_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_hit,
  output logic [ADDR_W:0]   occupancy,
  output logic              full,
  output logic              empty,
  output logic              err_rd_inv
);

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DATA_W-1:0] wr_word_d;
  logic [DATA_W-1:0] rd_word_d;
  logic              rd_hit_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, out_hit_q, err_q;

  buffer_valid_tracker #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_valid (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en_0),
    .wr_addr   (addr_in_wr),
    .clr_en    (op_en_1 & clr_on_rd),
    .clr_addr  (addr_in_rd),
    .valid     (valid),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  // Write word and read word selection; read sees pre-write contents unless bypassed.
  always_comb begin
    wr_word_d = byte_merge(mem_q[addr_in_wr], in_data, in_be);
`ifdef BUF_WR_BYPASS_EN
    if (wr_en_0 && (addr_in_wr == addr_in_rd)) begin
      rd_word_d = wr_word_d;
      rd_hit_d  = 1'b1;
    end else begin
      rd_word_d = mem_q[addr_in_rd];
      rd_hit_d  = valid[addr_in_rd];
    end
`else
    rd_word_d = mem_q[addr_in_rd];
    rd_hit_d  = valid[addr_in_rd];
`endif
  end

  // Data array: cleared on reset, byte-enabled write otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_0) begin
      mem_q[addr_in_wr] <= wr_word_d;
    end
  end

  // Read register, hit flag and sticky invalid-read error.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= op_en_1;
      if (op_en_1) begin
        out_data_q <= rd_word_d;
        out_hit_q  <= rd_hit_d;
        if (!rd_hit_d) err_q <= 1'b1;
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_hit    = out_hit_q;
  assign err_rd_inv = err_q;

endmodule

// File: tb/tb_buffer_top_param.sv
// Self-checking bench for buffer_top_param (default 64x8 build, either bypass option).
module tb_buffer_top_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  addr_in_wr, addr_in_rd;
  logic [63:0] in_data;
  logic [7:0]  in_be;
  logic        wr_en_0, op_en_1, clr_on_rd;
  logic [63:0] out_data;
  logic        out_valid, out_hit, full, empty, err_rd_inv;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  buffer_top_param dut (
    .clk        (clk),
    .rst        (rst),
    .addr_in_wr (addr_in_wr),
    .in_data    (in_data),
    .in_be      (in_be),
    .wr_en_0    (wr_en_0),
    .addr_in_rd (addr_in_rd),
    .op_en_1    (op_en_1),
    .clr_on_rd  (clr_on_rd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_hit    (out_hit),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .err_rd_inv (err_rd_inv)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents, valid flags and expected output registers.
  logic [63:0] m_mem [8];
  bit          m_valid [8];
  logic [63:0] e_data;
  bit          e_valid, e_hit, e_err;

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < 8; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] be);
    logic [63:0] r = o;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [63:0] rd_w;
    bit          rd_h;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_valid[i] = 0; end
      e_data = '0; e_valid = 0; e_hit = 0; e_err = 0;
    end else begin
      e_valid = op_en_1;
      if (op_en_1) begin
        rd_w = m_mem[addr_in_rd];
        rd_h = m_valid[addr_in_rd];
`ifdef BUF_WR_BYPASS_EN
        if (wr_en_0 && addr_in_wr == addr_in_rd) begin
          rd_w = merge(m_mem[addr_in_wr], in_data, in_be);
          rd_h = 1;
        end
`endif
        e_data = rd_w;
        e_hit  = rd_h;
        if (!rd_h) e_err = 1;
        if (clr_on_rd) m_valid[addr_in_rd] = 0;
      end
      if (wr_en_0) begin
        m_mem[addr_in_wr]   = merge(m_mem[addr_in_wr], in_data, in_be);
        m_valid[addr_in_wr] = 1;
      end
    end
  end

  // Compare DUT against the model on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_data",  out_data,          e_data);
      chk("m_out_valid", 64'(out_valid),    64'(e_valid));
      chk("m_out_hit",   64'(out_hit),      64'(e_hit));
      chk("m_err",       64'(err_rd_inv),   64'(e_err));
      chk("m_occupancy", 64'(occupancy),    64'(m_occ()));
      chk("m_full",      64'(full),         64'(m_occ() == 8));
      chk("m_empty",     64'(empty),        64'(m_occ() == 0));
    end
  end

  task automatic cyc(input logic r, input logic w, input logic [2:0] wa,
                     input logic [63:0] wd, input logic [7:0] be,
                     input logic rd, input logic [2:0] ra, input logic clr);
    rst = r; wr_en_0 = w; addr_in_wr = wa; in_data = wd; in_be = be;
    op_en_1 = rd; addr_in_rd = ra; clr_on_rd = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 3'd0, 64'd0, 8'h00, 0, 3'd0, 0);
  endtask

  logic [63:0] byp_exp;

  initial begin
    rst = 1; wr_en_0 = 0; addr_in_wr = 0; in_data = 0; in_be = 0;
    op_en_1 = 0; addr_in_rd = 0; clr_on_rd = 0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    idle();
    chk("rst_occ",   64'(occupancy),  64'd0);
    chk("rst_empty", 64'(empty),      64'd1);
    chk("rst_full",  64'(full),       64'd0);
    chk("rst_oval",  64'(out_valid),  64'd0);
    chk("rst_err",   64'(err_rd_inv), 64'd0);

    cyc(0, 1, 3'd3, 64'h1122334455667788, 8'hFF, 0, 3'd0, 0);
    cyc(0, 0, 3'd0, 64'd0, 8'h00, 1, 3'd3, 0);
    chk("rd3_data", out_data,        64'h1122334455667788);
    chk("rd3_val",  64'(out_valid),  64'd1);
    chk("rd3_hit",  64'(out_hit),    64'd1);
    chk("rd3_occ",  64'(occupancy),  64'd1);
    idle();
    chk("hold_data", out_data,       64'h1122334455667788);
    chk("hold_val",  64'(out_valid), 64'd0);

    cyc(0, 1, 3'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 3'd0, 0);
    cyc(0, 0, 3'd0, 64'd0, 8'h00, 1, 3'd3, 0);
    chk("be_merge", out_data, 64'h11223344AAAAAAAA);

    cyc(0, 0, 3'd0, 64'd0, 8'h00, 1, 3'd5, 0);
    chk("inv_hit",  64'(out_hit),    64'd0);
    chk("inv_err",  64'(err_rd_inv), 64'd1);
    chk("inv_data", out_data,        64'd0);

    for (int i = 0; i < 8; i++)
      cyc(0, 1, 3'(i), 64'hF0F0000000000000 | 64'(i), 8'hFF, 0, 3'd0, 0);
    chk("fill_occ",  64'(occupancy),  64'd8);
    chk("fill_full", 64'(full),       64'd1);
    chk("err_stick", 64'(err_rd_inv), 64'd1);

    cyc(0, 0, 3'd0, 64'd0, 8'h00, 1, 3'd0, 1);
    chk("clr_occ",  64'(occupancy), 64'd7);
    chk("clr_full", 64'(full),      64'd0);
    chk("clr_hit",  64'(out_hit),   64'd1);

`ifdef BUF_WR_BYPASS_EN
    byp_exp = 64'hFFFFFFFFFFFFFFFF;
`else
    byp_exp = 64'hF0F0000000000002;
`endif
    cyc(0, 1, 3'd2, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1, 3'd2, 1);
    chk("coll_data", out_data,       byp_exp);
    chk("coll_hit",  64'(out_hit),   64'd1);
    chk("coll_occ",  64'(occupancy), 64'd7);
    cyc(0, 0, 3'd0, 64'd0, 8'h00, 1, 3'd2, 0);
    chk("coll_rd2",  out_data,       64'hFFFFFFFFFFFFFFFF);
    chk("coll_hit2", 64'(out_hit),   64'd1);

    cyc(0, 1, 3'd0, 64'h123, 8'hFF, 1, 3'd1, 1);
    chk("net0_occ", 64'(occupancy), 64'd7);

    cyc(0, 1, 3'd4, 64'h4444, 8'hFF, 0, 3'd0, 0);
    cyc(1, 1, 3'd6, 64'h6666, 8'hFF, 1, 3'd6, 0);
    chk("mrst_occ",   64'(occupancy),  64'd0);
    chk("mrst_empty", 64'(empty),      64'd1);
    chk("mrst_err",   64'(err_rd_inv), 64'd0);
    chk("mrst_data",  out_data,        64'd0);
    chk("mrst_val",   64'(out_valid),  64'd0);
    cyc(0, 0, 3'd0, 64'd0, 8'h00, 1, 3'd6, 0);
    chk("mrst_rd6",   out_data,        64'd0);
    chk("mrst_hit6",  64'(out_hit),    64'd0);
    cyc(0, 0, 3'd0, 64'd0, 8'h00, 1, 3'd4, 0);
    chk("mrst_rd4",   out_data,        64'd0);

    cyc(0, 1, 3'd1, 64'hDEADBEEFDEADBEEF, 8'h00, 0, 3'd0, 0);
    cyc(0, 0, 3'd0, 64'd0, 8'h00, 1, 3'd1, 0);
    chk("be0_data", out_data,       64'd0);
    chk("be0_hit",  64'(out_hit),   64'd1);
    chk("be0_occ",  64'(occupancy), 64'd1);

    idle();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
